icache_refill: RTL and testbench

Direct-mapped instruction cache with a memory refill state machine, sitting directly upstream of the fetch stage. It serves whole 128-byte instruction lines to fetch, keyed by the fetch PC. On a miss it streams the line word-by-word from main memory, installs it, and then returns it. This replaces the fixed-delay miss model with a real, cycle-accurate refill.

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_line_store.sv | 48 ++++
 rtl/icache_refill.sv | 152 +++++++++++++++
 tb/tb_icache_refill.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants, address-split widths and FSM states for icache_refill
package icache_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int LINE_WORDS = 32;
  localparam int LINE_BYTES = 128;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESP
  } state_e;

  function automatic int offset_w();
    return $clog2(LINE_BYTES);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - offset_w() - index_w(lines);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - data/tag/valid arrays with combinational read and one write port
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 21,
  parameter int LINE_BITS = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic                 rd_valid_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic [LINE_BITS-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_data_i
);

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  // The write follows the clear so a line installed during an invalidate stays valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q <= '0;
      if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - direct-mapped icache with word-serial memory refill FSM
// Optional ICACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module icache_refill #(
  parameter int WORD_SIZE  = icache_pkg::WORD_SIZE,
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
  parameter int LINES      = 16,
  parameter int ADDR_W     = 32
) (
`ifdef ICACHE_STATS_EN
  output logic [31:0]                      hit_cnt,
  output logic [31:0]                      miss_cnt,
`endif
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fe_req,
  input  logic [ADDR_W-1:0]                fe_pc,
  output logic                             fe_ready,
  output logic                             fe_valid,
  output logic                             fe_miss,
  output logic [LINE_WORDS*WORD_SIZE-1:0]  fe_line,
  input  logic                             inv,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_rvalid,
  input  logic [WORD_SIZE-1:0]             mem_rdata
);
  import icache_pkg::*;

  localparam int LINE_BITS = LINE_WORDS * WORD_SIZE;
  localparam int OFF_W     = offset_w();
  localparam int IDX_W     = index_w(LINES);
  localparam int TAG_W     = tag_w(ADDR_W, LINES);
  localparam int BEAT_W    = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [LINE_BITS-1:0] fill_q, fill_d, line_q, line_d;
  logic                 hit_q, hit_d, miss_q, miss_d;

  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 accept, lookup_hit, beat_in, last_beat, pc_unused;

  assign pc_unused  = ^fe_pc[OFF_W-1:0];
  assign accept     = fe_req && (state_q == IDLE);
  assign lookup_hit = rd_valid && (rd_tag == fe_pc[ADDR_W-1 -: TAG_W]);
  assign beat_in    = (state_q == REFILL) && mem_rvalid;
  assign last_beat  = beat_in && (beat_q == LAST_BEAT);

  icache_line_store #(
    .LINES     (LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_BITS (LINE_BITS)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (inv),
    .rd_idx_i   (fe_pc[OFF_W +: IDX_W]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (last_beat),
    .wr_idx_i   (base_q[OFF_W +: IDX_W]),
    .wr_tag_i   (base_q[ADDR_W-1 -: TAG_W]),
    .wr_data_i  (fill_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !lookup_hit) state_d = REFILL;
      REFILL:  if (last_beat) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fe_ready = (state_q == IDLE);
    mem_req  = (state_q == REFILL);
    fe_valid = hit_q || (state_q == RESP);
  end

  // Beat k lands in word k counted from the top of the line.
  always_comb begin
    beat_d = beat_q;
    base_d = base_q;
    fill_d = fill_q;
    line_d = line_q;
    hit_d  = accept && lookup_hit;
    miss_d = accept && !lookup_hit;
    if (miss_d) begin
      base_d = {fe_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      beat_d = '0;
    end
    if (beat_in) begin
      fill_d[(LINE_WORDS - 1 - int'(beat_q)) * WORD_SIZE +: WORD_SIZE] = mem_rdata;
      beat_d = beat_q + BEAT_W'(1);
    end
    if (hit_d)     line_d = rd_data;
    if (last_beat) line_d = fill_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
      base_q <= '0;
      fill_q <= '0;
      line_q <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      base_q <= base_d;
      fill_q <= fill_d;
      line_q <= line_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign fe_miss  = miss_q;
  assign fe_line  = line_q;
  assign mem_addr = base_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_d && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_d && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - self-checking bench for icache_refill
module tb_icache_refill;

  logic          clk = 1'b0;
  logic          rst_n, fe_req, inv, mem_rvalid;
  logic [31:0]   fe_pc, mem_addr, mem_rdata;
  logic          fe_ready, fe_valid, fe_miss, mem_req;
  logic [1023:0] fe_line;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  icache_refill dut (
`ifdef ICACHE_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .fe_req     (fe_req),
    .fe_pc      (fe_pc),
    .fe_ready   (fe_ready),
    .fe_valid   (fe_valid),
    .fe_miss    (fe_miss),
    .fe_line    (fe_line),
    .inv        (inv),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference cache: per index, which line base is resident and its contents.
  bit            mv [16];
  logic [31:0]   mb [16];
  logic [1023:0] md [16];

  typedef struct {
    logic [31:0] addr;
    bit          exp_miss;
  } vec_t;
  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got line top %h bottom %h expected top %h bottom %h",
               name, act[1023:992], act[31:0], exp[1023:992], exp[31:0]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] addr);
    logic [31:0] base;
    int          idx;
    base = addr & ~32'h7F;
    idx  = int'((addr / 128) % 16);
    return mv[idx] && (mb[idx] == base);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; fe_req = 1'b0; inv = 1'b0; mem_rvalid = 1'b0;
    fe_pc = '0; mem_rdata = '0;
    repeat (3) step();
    rst_n = 1'b1;
    model_clear();
  endtask

  // One request; on a miss supplies the refill beats (random gaps) and follows it to completion.
  task automatic do_req(input logic [31:0] addr, input bit exp_miss, input bit pattern, input int inv_beat);
    logic [31:0]   base;
    logic [1023:0] line;
    int            idx;
    base = addr & ~32'h7F;
    idx  = int'((addr / 128) % 16);
    fe_pc = addr; fe_req = 1'b1;
    step();
    fe_req = 1'b0;
    chk("fe_miss", fe_miss, exp_miss);
    chk("fe_valid_t1", fe_valid, !exp_miss);
    if (!exp_miss) begin
      chk("hit_no_mem_req", mem_req, 0);
      chk_line("hit_line", fe_line, md[idx]);
    end else begin
      chk("mem_req", mem_req, 1);
      chk("mem_addr", mem_addr, base);
      line = '0;
      for (int k = 0; k < 32; k++) begin
        int          gap;
        logic [31:0] data;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          mem_rvalid = 1'b0; mem_rdata = $urandom;
          step();
        end
        data = pattern ? 32'h1000_0000 + 32'(k) : $urandom;
        mem_rvalid = 1'b1; mem_rdata = data;
        inv = (k == inv_beat);
        if (k == inv_beat) model_clear();
        step();
        inv = 1'b0;
        line[1023 - k*32 -: 32] = data;
        if (k == 31) chk("fe_valid_before_last", fe_valid, 1);
        else if (k == 16) chk("mem_req_mid", mem_req, 1);
      end
      mem_rvalid = 1'b0;
      chk_line("refill_line", fe_line, line);
      chk("mem_req_drop", mem_req, 0);
      chk("fe_ready_b1", fe_ready, 0);
      step();
      chk("fe_ready_b2", fe_ready, 1);
      chk("fe_valid_b2", fe_valid, 0);
      chk_line("line_hold", fe_line, line);
      mv[idx] = 1; mb[idx] = base; md[idx] = line;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h0000_0000, 1'b1};
    tbl[1] = '{32'h0000_0044, 1'b0};
    tbl[2] = '{32'h0000_0800, 1'b1};
    tbl[3] = '{32'h0000_0000, 1'b1};
    tbl[4] = '{32'h0000_0080, 1'b1};
    tbl[5] = '{32'h0000_00FC, 1'b0};
    tbl[6] = '{32'h0000_0010, 1'b0};
    tbl[7] = '{32'h0000_0880, 1'b1};

    do_reset();
    chk("rst_fe_ready", fe_ready, 1);
    chk("rst_fe_valid", fe_valid, 0);
    chk("rst_fe_miss", fe_miss, 0);
    chk_line("rst_fe_line", fe_line, '0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);

    for (int i = 0; i < 8; i++) begin
      do_req(tbl[i].addr, tbl[i].exp_miss, i == 0, -1);
      if (i == 0) begin
        chk("first_top_word", fe_line[1023:992], 32'h1000_0000);
        chk("first_bottom_word", fe_line[31:0], 32'h1000_001F);
      end
    end

    // Back-to-back hits on line 0x0
    fe_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fe_pc = 32'(i * 4);
      step();
      chk("burst_valid", fe_valid, 1);
      chk("burst_ready", fe_ready, 1);
      chk_line("burst_line", fe_line, md[0]);
    end
    fe_req = 1'b0;
    step();
    chk("burst_end_valid", fe_valid, 0);

    // Invalidate coincident with a lookup: lookup sees the old state
    fe_pc = 32'h0; fe_req = 1'b1; inv = 1'b1;
    step();
    fe_req = 1'b0; inv = 1'b0;
    chk("inv_same_cycle_hit", fe_valid, 1);
    chk("inv_same_cycle_miss", fe_miss, 0);
    model_clear();
    do_req(32'h0000_0000, 1'b1, 1'b0, -1);

    // Invalidate at beat 10 of a refill; the refilled line still lands valid
    do_req(32'h0000_0080, 1'b1, 1'b0, 10);
    do_req(32'h0000_00A0, 1'b0, 1'b0, -1);
    do_req(32'h0000_0000, 1'b1, 1'b0, -1);

    // Reset during beat 15
    fe_pc = 32'h0000_1000; fe_req = 1'b1;
    step();
    fe_req = 1'b0;
    chk("rstmid_miss", fe_miss, 1);
    for (int k = 0; k < 15; k++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_fe_ready", fe_ready, 1);
    for (int k = 0; k < 17; k++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      step();
      if (k == 16) begin
        chk("late_beats_mem_req", mem_req, 0);
        chk("late_beats_valid", fe_valid, 0);
      end
    end
    mem_rvalid = 1'b0;
    do_req(32'h0000_1000, 1'b1, 1'b0, -1);
    do_req(32'h0000_0000, 1'b1, 1'b0, -1);

    // Randomised requests against the reference cache
    for (int r = 0; r < 60; r++) begin
      logic [31:0] a;
      int          ib;
      a  = (32'($urandom_range(0, 1)) << 11) | (32'($urandom_range(0, 3)) << 7)
         | 32'($urandom_range(0, 127));
      ib = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
      do_req(a, !model_hit(a), 1'b0, ib);
    end

`ifdef ICACHE_STATS_EN
    do_reset();
    chk("stats_rst_hit", hit_cnt, 0);
    chk("stats_rst_miss", miss_cnt, 0);
    do_req(32'h0000_0000, 1'b1, 1'b0, -1);
    do_req(32'h0000_0080, 1'b1, 1'b0, -1);
    do_req(32'h0000_0100, 1'b1, 1'b0, -1);
    for (int i = 0; i < 7; i++) do_req(32'((i % 3) * 128 + 4), 1'b0, 1'b0, -1);
    chk("stats_hit", hit_cnt, 7);
    chk("stats_miss", miss_cnt, 3);
    inv = 1'b1;
    step();
    inv = 1'b0;
    step();
    chk("stats_inv_hit", hit_cnt, 7);
    chk("stats_inv_miss", miss_cnt, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
